// File: rtl/rv32_irq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv32_irq_pkg
//  Purpose  : Shared types, constants and the vector-address helper for the
//             interrupt controller.
//  Contents : irq_state_t, IRQ_TIMER, default vector base/stride, vec_addr()
//  Revision : 1.0  initial release
// ============================================================================
package rv32_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  // Timer interrupt is wired to source line 0 at core level.
  localparam int          IRQ_TIMER       = 0;
  localparam logic [31:0] VEC_BASE_DFLT   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DFLT = 32'd4;

  // 32-bit unsigned; overflow wraps modulo 2^32 by truncation.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Purpose  : Combinational find-first-set; lowest set index wins.
//  Ports    : req   in  NUM_IRQ  candidate lines (pending & enabled)
//             valid out 1        at least one candidate present
//             index out ID_W     index of the lowest set bit (0 if none)
//  Revision : 1.0  initial release
// ============================================================================
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    index
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = ID_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : irq_controller
//  Purpose  : Latches rising edges of interrupt lines as pending, selects the
//             lowest-index pending & enabled line, requests a trap from fetch
//             with its vector, and holds the return PC until mret.
//             Single level, no nesting.
//  Ports    : clk, reset (async, active-low)
//             irq_src      raw level interrupt lines
//             global_en    master enable
//             en_wr/en_wdata    enable-mask write
//             clr_wr/clr_wdata  pending-clear write
//             trap_ack, current_pc  fetch handshake / PC to save
//             mret         return from handler
//             irq_en, pending, trap_req, trap_vec, trap_id, in_service, epc
//  Revision : 1.0  initial release
// ============================================================================
module irq_controller
  import rv32_irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DFLT,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IRQ-1:0]         irq_src,
  input  logic                       global_en,
  input  logic                       en_wr,
  input  logic [NUM_IRQ-1:0]         en_wdata,
  input  logic                       clr_wr,
  input  logic [NUM_IRQ-1:0]         clr_wdata,
  input  logic                       trap_ack,
  input  logic [31:0]                current_pc,
  input  logic                       mret,
  output logic [NUM_IRQ-1:0]         irq_en,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       trap_req,
  output logic [31:0]                trap_vec,
  output logic [$clog2(NUM_IRQ)-1:0] trap_id,
  output logic                       in_service,
  output logic [31:0]                epc
);

  localparam int ID_W = $clog2(NUM_IRQ);

  irq_state_t         state;
  logic [NUM_IRQ-1:0] irq_sync;   // first sample of the raw lines
  logic [NUM_IRQ-1:0] irq_src_q;  // previous sample, for edge detection
  logic               reset_q;    // low for the first cycle after reset
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_idx;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (pending & irq_en),
    .valid (sel_valid),
    .index (sel_idx)
  );

  // Edge detection is disabled until reset_q is set, so a line held high
  // across reset release is absorbed as the baseline rather than an edge.
  assign rise     = reset_q ? (irq_sync & ~irq_src_q) : '0;
  assign clr_mask = clr_wr ? clr_wdata : '0;

  always_comb begin
    ack_clr = '0;
    if (state == IRQ_REQ && trap_ack) ack_clr[trap_id] = 1'b1;
  end

  // Input sampling and the pending / enable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_sync  <= '0;
      irq_src_q <= '0;
      reset_q   <= 1'b0;
      pending   <= '0;
      irq_en    <= '0;
    end else begin
      reset_q   <= 1'b1;
      irq_sync  <= irq_src;
      // On the first post-reset cycle both stages load the live lines.
      irq_src_q <= reset_q ? irq_sync : irq_src;
      // A new rise takes precedence over any clear on the same bit.
      pending   <= (pending & ~clr_mask & ~ack_clr) | rise;
      if (en_wr) irq_en <= en_wdata;
    end
  end

  // Trap FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IRQ_IDLE;
      trap_req   <= 1'b0;
      trap_id    <= '0;
      trap_vec   <= '0;
      in_service <= 1'b0;
      epc        <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (global_en && sel_valid) begin
            state    <= IRQ_REQ;
            trap_req <= 1'b1;
            trap_id  <= sel_idx;
            trap_vec <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(sel_idx));
          end
        end
        IRQ_REQ: begin
          // The request is committed: neither global_en nor newer lines
          // can withdraw or retarget it before the ack.
          if (trap_ack) begin
            state      <= IRQ_SERVICE;
            trap_req   <= 1'b0;
            in_service <= 1'b1;
            epc        <= current_pc;
          end
        end
        IRQ_SERVICE: begin
          if (mret) begin
            state      <= IRQ_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IRQ_IDLE;
          trap_req   <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_irq_controller
//  Purpose  : Directed, table-driven self-checking bench for irq_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic        global_en;
  logic        en_wr;
  logic [3:0]  en_wdata;
  logic        clr_wr;
  logic [3:0]  clr_wdata;
  logic        trap_ack;
  logic [31:0] current_pc;
  logic        mret;
  logic [3:0]  irq_en;
  logic [3:0]  pending;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic [1:0]  trap_id;
  logic        in_service;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .global_en  (global_en),
    .en_wr      (en_wr),
    .en_wdata   (en_wdata),
    .clr_wr     (clr_wr),
    .clr_wdata  (clr_wdata),
    .trap_ack   (trap_ack),
    .current_pc (current_pc),
    .mret       (mret),
    .irq_en     (irq_en),
    .pending    (pending),
    .trap_req   (trap_req),
    .trap_vec   (trap_vec),
    .trap_id    (trap_id),
    .in_service (in_service),
    .epc        (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic        gen;
    logic        enw;
    logic [3:0]  end_;
    logic        clrw;
    logic [3:0]  clrd;
    logic        ack;
    logic [31:0] pc;
    logic        mr;
    logic [3:0]  x_en;
    logic [3:0]  x_pend;
    logic        x_req;
    logic [1:0]  x_id;
    logic [31:0] x_vec;
    logic        x_ins;
    logic [31:0] x_epc;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] src, input logic gen,
                              input logic enw, input logic [3:0] end_,
                              input logic clrw, input logic [3:0] clrd,
                              input logic ack, input logic [31:0] pc,
                              input logic mr,
                              input logic [3:0] x_en, input logic [3:0] x_pend,
                              input logic x_req, input logic [1:0] x_id,
                              input logic [31:0] x_vec, input logic x_ins,
                              input logic [31:0] x_epc);
    vec_t v;
    v.src = src; v.gen = gen; v.enw = enw; v.end_ = end_;
    v.clrw = clrw; v.clrd = clrd; v.ack = ack; v.pc = pc; v.mr = mr;
    v.x_en = x_en; v.x_pend = x_pend; v.x_req = x_req; v.x_id = x_id;
    v.x_vec = x_vec; v.x_ins = x_ins; v.x_epc = x_epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, "_irq_en"},     32'(irq_en),     32'(v.x_en));
    chk({tag, "_pending"},    32'(pending),    32'(v.x_pend));
    chk({tag, "_trap_req"},   32'(trap_req),   32'(v.x_req));
    chk({tag, "_trap_id"},    32'(trap_id),    32'(v.x_id));
    chk({tag, "_trap_vec"},   trap_vec,        v.x_vec);
    chk({tag, "_in_service"}, 32'(in_service), 32'(v.x_ins));
    chk({tag, "_epc"},        epc,             v.x_epc);
  endtask

  vec_t tbl[$];
  vec_t zero_v;
  int   n;

  initial begin
    // src gen enw end clrw clrd ack pc mr | en pend req id vec ins epc
    // Single pulse on line 0: pending after 2 clk, request after 3.
    tbl.push_back(mk(4'h0,1,1,4'h1,0,4'h0,0,32'h0, 0, 4'h1,4'h0,0,2'd0,32'h0,  0,32'h0));
    tbl.push_back(mk(4'h1,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h1,4'h0,0,2'd0,32'h0,  0,32'h0));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h1,4'h1,0,2'd0,32'h0,  0,32'h0));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h1,4'h1,1,2'd0,32'h100,0,32'h0));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,1,32'h20,0, 4'h1,4'h0,0,2'd0,32'h100,1,32'h20));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 1, 4'h1,4'h0,0,2'd0,32'h100,0,32'h20));
    // Lines 3 and 1 together: 1 first, then 3 after mret.
    tbl.push_back(mk(4'hA,1,1,4'hF,0,4'h0,0,32'h0, 0, 4'hF,4'h0,0,2'd0,32'h100,0,32'h20));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'hF,4'hA,0,2'd0,32'h100,0,32'h20));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'hF,4'hA,1,2'd1,32'h104,0,32'h20));
    tbl.push_back(mk(4'hA,0,0,4'h0,0,4'h0,0,32'h0, 0, 4'hF,4'hA,1,2'd1,32'h104,0,32'h20));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,1,32'h40,0, 4'hF,4'h8,0,2'd1,32'h104,1,32'h40));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,1,32'h99,0, 4'hF,4'h8,0,2'd1,32'h104,1,32'h40));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,0,32'h0, 1, 4'hF,4'h8,0,2'd1,32'h104,0,32'h40));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'hF,4'h8,1,2'd3,32'h10C,0,32'h40));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,0,32'h0, 1, 4'hF,4'h8,1,2'd3,32'h10C,0,32'h40));
    tbl.push_back(mk(4'hA,1,0,4'h0,0,4'h0,1,32'h50,0, 4'hF,4'h0,0,2'd3,32'h10C,1,32'h50));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 1, 4'hF,4'h0,0,2'd3,32'h10C,0,32'h50));
    // Disabled line 2 latches but does not request until enabled.
    tbl.push_back(mk(4'h4,1,1,4'h0,0,4'h0,0,32'h0, 0, 4'h0,4'h0,0,2'd3,32'h10C,0,32'h50));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h0,4'h4,0,2'd3,32'h10C,0,32'h50));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h0,4'h4,0,2'd3,32'h10C,0,32'h50));
    tbl.push_back(mk(4'h0,1,1,4'h4,0,4'h0,0,32'h0, 0, 4'h4,4'h4,0,2'd3,32'h10C,0,32'h50));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h4,4'h4,1,2'd2,32'h108,0,32'h50));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,1,32'h60,0, 4'h4,4'h0,0,2'd2,32'h108,1,32'h60));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,0,32'h0, 1, 4'h4,4'h0,0,2'd2,32'h108,0,32'h60));
    // Set beats clear on line 0, then a plain clear; ack in IDLE ignored.
    tbl.push_back(mk(4'h1,1,0,4'h0,0,4'h0,0,32'h0, 0, 4'h4,4'h0,0,2'd2,32'h108,0,32'h60));
    tbl.push_back(mk(4'h1,1,0,4'h0,1,4'h1,0,32'h0, 0, 4'h4,4'h1,0,2'd2,32'h108,0,32'h60));
    tbl.push_back(mk(4'h1,1,0,4'h0,1,4'h1,0,32'h0, 0, 4'h4,4'h0,0,2'd2,32'h108,0,32'h60));
    tbl.push_back(mk(4'h0,1,0,4'h0,0,4'h0,1,32'h77,0, 4'h4,4'h0,0,2'd2,32'h108,0,32'h60));

    zero_v = mk(4'h0,0,0,4'h0,0,4'h0,0,32'h0,0, 4'h0,4'h0,0,2'd0,32'h0,0,32'h0);

    // Reset with all lines high: every output zero.
    reset = 1'b0; irq_src = 4'hF; global_en = 1'b1; en_wr = 1'b0;
    en_wdata = 4'h0; clr_wr = 1'b0; clr_wdata = 4'h0; trap_ack = 1'b0;
    current_pc = 32'h0; mret = 1'b0;
    repeat (3) tick();
    chk_all("reset", zero_v);

    // Release with lines still high: nothing latches.
    reset = 1'b1; en_wr = 1'b1; en_wdata = 4'hF;
    tick();
    en_wr = 1'b0;
    repeat (3) tick();
    chk("rel_pending",  32'(pending),  32'h0);
    chk("rel_trap_req", 32'(trap_req), 32'h0);
    chk("rel_irq_en",   32'(irq_en),   32'hF);
    irq_src = 4'h0;
    repeat (2) tick();
    chk("rel_fall_pending", 32'(pending), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      irq_src = tbl[i].src; global_en = tbl[i].gen; en_wr = tbl[i].enw;
      en_wdata = tbl[i].end_; clr_wr = tbl[i].clrw; clr_wdata = tbl[i].clrd;
      trap_ack = tbl[i].ack; current_pc = tbl[i].pc; mret = tbl[i].mr;
      tick();
      chk_all($sformatf("v%0d", i), tbl[i]);
    end

    // Reset in the middle of SERVICE.
    irq_src = 4'h0; global_en = 1'b1; en_wr = 1'b1; en_wdata = 4'h1;
    clr_wr = 1'b0; trap_ack = 1'b0; mret = 1'b0; current_pc = 32'h0;
    tick();
    en_wr = 1'b0; irq_src = 4'h1;
    tick();
    irq_src = 4'h0;
    n = 0;
    while (!trap_req && n < 10) begin
      tick();
      n++;
    end
    chk("svc_trap_req", 32'(trap_req), 32'h1);
    chk("svc_trap_id",  32'(trap_id),  32'h0);
    trap_ack = 1'b1; current_pc = 32'h80;
    tick();
    trap_ack = 1'b0;
    chk("svc_in_service", 32'(in_service), 32'h1);
    chk("svc_epc",        epc,             32'h80);
    #2 reset = 1'b0;
    #1;
    chk_all("midrst", zero_v);
    repeat (2) tick();
    reset = 1'b1; en_wr = 1'b1; en_wdata = 4'h1;
    tick();
    en_wr = 1'b0; irq_src = 4'h1;
    n = 0;
    do begin
      tick();
      n++;
      irq_src = 4'h0;
    end while (!trap_req && n < 10);
    chk("post_latency",  32'(n),        32'd3);
    chk("post_trap_vec", trap_vec,      32'h100);
    chk("post_trap_id",  32'(trap_id),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
